adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 141 ++++++++++++++
 tb/tb_adc_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Dual-channel ADC capture: records len {da,db} pairs into a FIFO and streams
// them out through a registered valid/ready stage, with sticky overflow on drops.
module adc_capture #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       da,
    input  logic [WIDTH-1:0]       db,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   len,
    output logic [2*WIDTH-1:0]     m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 accept;
    logic                 full;
    logic                 empty;
    logic                 avail;
    logic                 wr_en;
    logic                 rd_en;
    logic                 last;

    // Full/empty use the live write pointer; the read side sees writes one
    // cycle late, which gives the two-cycle write-to-valid latency.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign avail = (wr_ptr_q != rd_ptr);
    assign wr_en = (state == CAPTURE) && !full;
    assign rd_en = avail && (!m_valid || m_ready);
    assign last  = (cnt == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt = CAPTURE;
                    accept    = 1'b1;
                end
            end
            CAPTURE: begin
                if (last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && (!m_valid || m_ready)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sample storage; pointers alone define occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {da, db};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ptr_q <= '0;
            len_q    <= '0;
            cnt      <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= (state == DRAIN) && (state_nxt == IDLE);
            wr_ptr_q <= wr_ptr;

            // Dropped samples still advance the counter to keep the window length.
            if (accept) begin
                len_q    <= len;
                cnt      <= '0;
                overflow <= 1'b0;
            end else if (state == CAPTURE) begin
                cnt <= cnt + LEN_WIDTH'(1);
                if (full) begin
                    overflow <= 1'b1;
                end
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (rd_en) begin
                rd_ptr  <= rd_ptr + PW'(1);
                m_data  <= mem[rd_ptr[AW-1:0]];
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: a deep (1024) and a shallow (4) instance
// share stimulus; delivered words are compared against the captured sample list.
module tb_adc_capture;

    localparam int unsigned W  = 12;
    localparam int unsigned LW = 16;
    localparam int unsigned DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          m_ready;
    logic [W-1:0]  da;
    logic [W-1:0]  db;
    logic [LW-1:0] len;
    logic [DW-1:0] m_data1, m_data4;
    logic          m_valid1, m_valid4;
    logic          busy1, busy4, done1, done4, ovf1, ovf4;

    adc_capture #(.WIDTH(W), .DEPTH(1024), .LEN_WIDTH(LW)) dut1 (
        .clk(clk), .rst(rst), .da(da), .db(db), .start(start), .len(len),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .busy(busy1), .done(done1), .overflow(ovf1)
    );

    adc_capture #(.WIDTH(W), .DEPTH(4), .LEN_WIDTH(LW)) dut4 (
        .clk(clk), .rst(rst), .da(da), .db(db), .start(start), .len(len),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .busy(busy4), .done(done4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int ready_mode;   // 0: stalled through capture then ready, 1: always, 2: random
        bit rnd_data;
        int pulse_at;     // loop cycle at which a stray start is pulsed, -1 for none
        bit chk4;
        int exp4_n;
        bit exp4_ovf;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            smp = 0;
    int            done_cnt1 = 0;
    int            done_cnt4 = 0;
    logic [DW-1:0] samp[$];
    logic [DW-1:0] rx1[$];
    logic [DW-1:0] rx4[$];
    logic [DW-1:0] hold1, hold4;
    bit            stall1 = 1'b0;
    bit            stall4 = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Index of the first word that differs from the sample list, -1 if all n match.
    function automatic int first_bad(input logic [DW-1:0] q[$], input int n);
        for (int k = 0; k < n; k++) begin
            if (k >= q.size()) return k;
            if (q[k] !== samp[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic ready_val(input vec_t v, input int t);
        case (v.ready_mode)
            0:       return (t > v.len + 8);
            1:       return 1'b1;
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (smp < samp.size()) begin
            da = samp[smp][DW-1:W];
            db = samp[smp][W-1:0];
        end else begin
            da = W'($urandom);
            db = W'($urandom);
        end
        smp++;
    endtask

    // Transfer/done monitor and stall-stability checks, half a cycle from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall1 = 1'b0;
                stall4 = 1'b0;
            end else begin
                if (stall1) check("hold1", longint'({m_valid1, m_data1}), longint'({1'b1, hold1}));
                if (stall4) check("hold4", longint'({m_valid4, m_data4}), longint'({1'b1, hold4}));
                if (m_valid1 && m_ready) rx1.push_back(m_data1);
                if (m_valid4 && m_ready) rx4.push_back(m_data4);
                if (done1) done_cnt1++;
                if (done4) done_cnt4++;
                stall1 = m_valid1 && !m_ready;
                stall4 = m_valid4 && !m_ready;
                hold1  = m_data1;
                hold4  = m_data4;
            end
        end
    end

    task automatic run_capture(input vec_t v, input string tag);
        int cs;
        int lat1;
        int lat4;
        int budget;
        samp.delete();
        rx1.delete();
        rx4.delete();
        done_cnt1 = 0;
        done_cnt4 = 0;
        for (int k = 0; k < v.len; k++) begin
            samp.push_back(v.rnd_data ? DW'($urandom) : {W'(k), W'(12'h800 + k)});
        end
        start   = 1'b1;
        len     = LW'(v.len);
        m_ready = ready_val(v, 0);
        smp     = 0;
        step();
        cs = cyc;
        check({tag, " busy"}, longint'({busy1, busy4}), 2'b11);
        check({tag, " ovf_clear"}, longint'({ovf1, ovf4}), 2'b00);
        lat1   = -1;
        lat4   = -1;
        budget = 4 * v.len + 100;
        for (int t = 1; t <= budget && !(done_cnt1 > 0 && done_cnt4 > 0); t++) begin
            start   = (t == v.pulse_at);
            len     = (t == v.pulse_at) ? LW'(3) : LW'(v.len);
            m_ready = ready_val(v, t);
            step();
            if (lat1 < 0 && m_valid1) lat1 = cyc - cs;
            if (lat4 < 0 && m_valid4) lat4 = cyc - cs;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        repeat (5) step();
        check({tag, " done1"}, done_cnt1, 1);
        check({tag, " done4"}, done_cnt4, 1);
        check({tag, " latency1"}, lat1, 3);
        check({tag, " latency4"}, lat4, 3);
        check({tag, " count1"}, rx1.size(), v.len);
        check({tag, " data1"}, first_bad(rx1, v.len), -1);
        check({tag, " ovf1"}, ovf1, 0);
        check({tag, " idle"}, longint'({busy1, busy4}), 2'b00);
        if (v.chk4) begin
            check({tag, " count4"}, rx4.size(), v.exp4_n);
            check({tag, " data4"}, first_bad(rx4, v.exp4_n), -1);
            check({tag, " ovf4"}, ovf4, longint'(v.exp4_ovf));
        end
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = '{8,    1, 1'b0, -1, 1'b1, 8, 1'b0};   // basic ramp
        tbl[1] = '{1,    1, 1'b1, -1, 1'b1, 1, 1'b0};   // single pair
        tbl[2] = '{1000, 2, 1'b1, -1, 1'b0, 0, 1'b0};   // random ready, long capture
        tbl[3] = '{3,    2, 1'b1, -1, 1'b1, 3, 1'b0};   // short random
        tbl[4] = '{6,    1, 1'b0,  2, 1'b1, 6, 1'b0};   // stray start during capture
        tbl[5] = '{4,    0, 1'b0, -1, 1'b1, 4, 1'b0};   // backpressure, fits
        tbl[6] = '{10,   0, 1'b0, -1, 1'b1, 5, 1'b1};   // backpressure, overflows

        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        da      = '0;
        db      = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outs1", longint'({m_valid1, busy1, done1, ovf1, m_data1}), 0);
        check("reset outs4", longint'({m_valid4, busy4, done4, ovf4, m_data4}), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_capture(tbl[i], $sformatf("vec%0d", i));
        end

        // Zero-length request is ignored and leaves the sticky flag alone.
        done_cnt1 = 0;
        done_cnt4 = 0;
        start     = 1'b1;
        len       = '0;
        repeat (3) step();
        start = 1'b0;
        repeat (2) step();
        check("len0 busy", longint'({busy1, busy4}), 2'b00);
        check("len0 done", done_cnt1 + done_cnt4, 0);
        check("len0 ovf", longint'({ovf1, ovf4}), 2'b01);

        // Reset after three writes of an eight-pair capture.
        samp.delete();
        rx1.delete();
        rx4.delete();
        for (int k = 0; k < 8; k++) samp.push_back({W'(k), W'(12'h800 + k)});
        start   = 1'b1;
        len     = LW'(8);
        m_ready = 1'b0;
        smp     = 0;
        step();
        start = 1'b0;
        check("rstcap ovf_clear", longint'({ovf1, ovf4}), 2'b00);
        repeat (3) step();
        check("rstcap valid", longint'({m_valid1, m_valid4}), 2'b11);
        rst = 1'b1;
        #1;
        check("rstcap outs1", longint'({m_valid1, busy1, done1, ovf1, m_data1}), 0);
        check("rstcap outs4", longint'({m_valid4, busy4, done4, ovf4, m_data4}), 0);
        repeat (2) step();
        rst       = 1'b0;
        done_cnt1 = 0;
        done_cnt4 = 0;
        m_ready   = 1'b1;
        repeat (6) step();
        check("rstcap no_done", done_cnt1 + done_cnt4, 0);
        check("rstcap no_words", rx1.size() + rx4.size(), 0);
        v = '{2, 1, 1'b1, -1, 1'b1, 2, 1'b0};
        run_capture(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
